// File: rtl/gray_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : gray_ptr_sync
// Description : Brings a Gray-coded pointer from a foreign clock domain into
//               clk through a plain flop chain, converts it to binary and
//               reports each advance as a one-cycle valid pulse with the
//               advance amount.  A Gray step that flips more than one bit is
//               flagged as an error (pulse plus sticky flag).
// Ports       : clk        - single rising-edge clock
//               rst        - asynchronous active-high reset
//               gray_in    - Gray pointer, asynchronous to clk
//               err_clr    - synchronous clear of err_sticky
//               gray_sync  - last synchronizer stage
//               binary_out - registered binary of gray_sync
//               valid_out  - one-cycle pulse when binary_out changes
//               delta      - binary_out advance (mod 2^WIDTH), valid with
//                            valid_out
//               err        - one-cycle pulse on a multi-bit Gray change
//               err_sticky - latched error flag
// Revision    : 1.0 - initial release
// ============================================================================
module gray_ptr_sync #(
    parameter int WIDTH       = 8,   // pointer width, >= 2
    parameter int SYNC_STAGES = 2    // synchronizer depth, >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] gray_sync,
    output logic [WIDTH-1:0] binary_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] delta,
    output logic             err,
    output logic             err_sticky
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Synchronizer chain: nothing but flops between stages, so every bit
    // gets the full settling time of each stage.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync[0] <= '0;
        end else begin
            r_sync[0] <= gray_in;
        end
    end

    generate
        for (genvar s = 1; s < SYNC_STAGES; s++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync[s] <= '0;
                end else begin
                    r_sync[s] <= r_sync[s-1];
                end
            end
        end
    endgenerate

    assign gray_sync = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Gray to binary: bit i is the XOR of all Gray bits at or above i,
    // which is the reduction XOR of the value shifted down by i.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_bin;

    always_comb begin
        w_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bin[i] = ^(gray_sync >> i);
        end
    end

    // ------------------------------------------------------------------
    // Change / error detection against the previous synchronized value.
    // x & (x-1) clears the lowest set bit; a nonzero result means at
    // least two bits flipped in one step.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_gray_prev;
    logic [WIDTH-1:0] w_diff;
    logic             w_change;
    logic             w_multi;
    logic             w_err_next;

    assign w_diff     = gray_sync ^ r_gray_prev;
    assign w_change   = |w_diff;
    assign w_multi    = |(w_diff & (w_diff - c_one));
    assign w_err_next = w_change & w_multi;

    // ------------------------------------------------------------------
    // Output registers.  r_bin always equals the binary of r_gray_prev,
    // so the delta subtraction uses the value published last cycle.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_delta;
    logic             r_valid;
    logic             r_err;
    logic             r_err_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gray_prev <= '0;
            r_bin       <= '0;
            r_delta     <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_gray_prev <= gray_sync;
            r_bin       <= w_bin;
            r_valid     <= w_change;
            r_err       <= w_err_next;
            if (w_change) begin
                r_delta <= w_bin - r_bin;
            end
        end
    end

    // The sticky flag sets alongside the err pulse and is held through the
    // cycle the pulse is visible, so a clear coinciding with err loses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_err_next || r_err) begin
            r_err_sticky <= 1'b1;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
        end
    end

    assign binary_out = r_bin;
    assign valid_out  = r_valid;
    assign delta      = r_delta;
    assign err        = r_err;
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_gray_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_ptr_sync
// Description : Directed self-checking bench for gray_ptr_sync with
//               WIDTH=8, SYNC_STAGES=2.  Inputs change 1 time unit after a
//               rising edge; outputs are checked at that same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_ptr_sync;

    logic       clk;
    logic       rst;
    logic [7:0] gray_in;
    logic       err_clr;
    logic [7:0] gray_sync;
    logic [7:0] binary_out;
    logic       valid_out;
    logic [7:0] delta;
    logic       err;
    logic       err_sticky;

    int n_cmp;
    int n_bad;

    gray_ptr_sync #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .gray_in    (gray_in),
        .err_clr    (err_clr),
        .gray_sync  (gray_sync),
        .binary_out (binary_out),
        .valid_out  (valid_out),
        .delta      (delta),
        .err        (err),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance to 1 unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gsync"},  32'(gray_sync),  32'h0);
        chk({tag, "_bin"},    32'(binary_out), 32'h0);
        chk({tag, "_valid"},  32'(valid_out),  32'h0);
        chk({tag, "_delta"},  32'(delta),      32'h0);
        chk({tag, "_err"},    32'(err),        32'h0);
        chk({tag, "_sticky"}, 32'(err_sticky), 32'h0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        gray_in = 8'h00;
        err_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : main
        int         vcount;
        logic [7:0] b;
        logic [7:0] g;

        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        gray_in = 8'h00;
        err_clr = 1'b0;

        // ---- reset release with input at zero: nothing ever happens ----
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("rst_state");
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid_out) vcount++;
        end
        chk("idle_no_valid", 32'(vcount), 32'd0);
        chk_all_zero("idle_state");

        // ---- first step 0x00 -> 0x01, latency check ----
        gray_in = 8'h01;
        tick();                                          // edge 1
        chk("lat_e1_gsync", 32'(gray_sync), 32'h00);
        tick();                                          // edge 2
        chk("lat_e2_gsync", 32'(gray_sync), 32'h01);
        chk("lat_e2_valid", 32'(valid_out), 32'h0);
        chk("lat_e2_bin",   32'(binary_out), 32'h00);
        tick();                                          // edge 3
        chk("lat_e3_bin",   32'(binary_out), 32'h01);
        chk("lat_e3_valid", 32'(valid_out),  32'h1);
        chk("lat_e3_delta", 32'(delta),      32'h01);
        chk("lat_e3_err",   32'(err),        32'h0);
        tick();                                          // edge 4
        chk("lat_e4_valid", 32'(valid_out),  32'h0);
        chk("lat_e4_delta_hold", 32'(delta), 32'h01);

        // ---- walk binary 2..255 then wrap to 0, one code every 3 cycles ----
        for (int k = 2; k <= 256; k++) begin
            b = 8'(k);
            g = b ^ (b >> 1);
            gray_in = g;
            vcount = 0;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (valid_out) vcount++;
            end
            chk("walk_valid_cnt", 32'(vcount),     32'd1);
            chk("walk_valid",     32'(valid_out),  32'h1);
            chk("walk_bin",       32'(binary_out), 32'(b));
            chk("walk_delta",     32'(delta),      32'h01);
            chk("walk_err",       32'(err),        32'h0);
        end
        chk("wrap_gsync",  32'(gray_sync),  32'h00);
        chk("wrap_bin",    32'(binary_out), 32'h00);
        chk("wrap_delta",  32'(delta),      32'h01);
        chk("wrap_sticky", 32'(err_sticky), 32'h0);

        // ---- illegal two-bit jump 0x00 -> 0x03 (binary 2) ----
        gray_in = 8'h03;
        tick();
        tick();
        tick();
        chk("jump_valid",  32'(valid_out),  32'h1);
        chk("jump_bin",    32'(binary_out), 32'h02);
        chk("jump_delta",  32'(delta),      32'h02);
        chk("jump_err",    32'(err),        32'h1);
        chk("jump_sticky", 32'(err_sticky), 32'h1);
        err_clr = 1'b1;                                  // coincides with err
        tick();
        chk("clr_coinc_err",    32'(err),        32'h0);
        chk("clr_coinc_sticky", 32'(err_sticky), 32'h1);
        tick();                                          // clear one cycle later
        chk("clr_late_sticky",  32'(err_sticky), 32'h0);
        err_clr = 1'b0;
        tick();
        chk("clr_stays_low",    32'(err_sticky), 32'h0);

        // ---- asynchronous reset: outputs drop without a clock edge ----
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_bin",  32'(binary_out), 32'h00);
        chk("async_rst_gsync", 32'(gray_sync), 32'h00);
        do_reset();

        // ---- back-to-back changes 0x00 -> 0x01 -> 0x03 ----
        gray_in = 8'h01;
        tick();                                          // edge 1
        gray_in = 8'h03;
        tick();                                          // edge 2
        chk("b2b_e2_valid", 32'(valid_out), 32'h0);
        tick();                                          // edge 3
        chk("b2b_e3_valid", 32'(valid_out),  32'h1);
        chk("b2b_e3_bin",   32'(binary_out), 32'h01);
        chk("b2b_e3_delta", 32'(delta),      32'h01);
        tick();                                          // edge 4
        chk("b2b_e4_valid", 32'(valid_out),  32'h1);
        chk("b2b_e4_bin",   32'(binary_out), 32'h02);
        chk("b2b_e4_delta", 32'(delta),      32'h01);
        chk("b2b_e4_err",   32'(err),        32'h0);
        tick();                                          // edge 5
        chk("b2b_e5_valid", 32'(valid_out),  32'h0);
        chk("b2b_e5_sticky", 32'(err_sticky), 32'h0);

        // ---- reset between edge 2 and edge 3 of the first-step sequence ----
        do_reset();
        gray_in = 8'h01;
        tick();                                          // edge 1
        tick();                                          // edge 2
        chk("mid_e2_gsync", 32'(gray_sync), 32'h01);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        tick();                                          // edge while in reset
        chk("mid_rst_held_valid", 32'(valid_out), 32'h0);
        rst = 1'b0;
        tick();                                          // edge 1'
        chk("mid_e1_valid", 32'(valid_out), 32'h0);
        tick();                                          // edge 2'
        chk("mid_e2p_gsync", 32'(gray_sync), 32'h01);
        chk("mid_e2p_valid", 32'(valid_out), 32'h0);
        tick();                                          // edge 3'
        chk("mid_e3_valid", 32'(valid_out),  32'h1);
        chk("mid_e3_delta", 32'(delta),      32'h01);
        chk("mid_e3_bin",   32'(binary_out), 32'h01);
        chk("mid_e3_err",   32'(err),        32'h0);

        // ---- reset during a valid pulse aborts it immediately ----
        #2;
        rst = 1'b1;
        #1;
        chk("pulse_abort_valid", 32'(valid_out), 32'h0);
        chk("pulse_abort_delta", 32'(delta),     32'h00);
        gray_in = 8'h00;
        tick();
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid_out) vcount++;
        end
        chk("pulse_abort_no_replay", 32'(vcount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
